// File: rtl/tnn_feature_sequencer.sv
// tnn_feature_sequencer: collects a 7-feature frame over valid/ready, holds it on the
// classifier inputs for a settle window, captures the result bit and keeps
// saturating accuracy-monitoring counters.
module tnn_feature_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             feat_valid,
  output logic             feat_ready,
  input  logic [1:0]       feat_data,
  input  logic             feat_last,
  output logic [1:0]       cls_a,
  output logic [1:0]       cls_b,
  output logic [1:0]       cls_c,
  output logic [1:0]       cls_d,
  output logic [1:0]       cls_e,
  output logic [1:0]       cls_f,
  output logic [1:0]       cls_g,
  input  logic             cls_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_data,
  output logic             frame_err,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] pos_cnt
);

  localparam int unsigned N_FEAT   = 7;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned LAST_IDX = N_FEAT - 1;
  localparam int unsigned SET_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_EVAL = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [1:0]         slot_q [N_FEAT];
  logic               wr_en;
  logic               capture;
  logic               err_d;
  logic               handshake;

  // Ready is held low while reset is asserted so nothing is accepted in that cycle.
  assign feat_ready = (state_q == S_LOAD) & ~rst;
  assign handshake  = feat_valid & feat_ready;

  // Next-state, slot write enable, capture strobe and framing-error decode.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    wr_en    = 1'b0;
    capture  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (handshake) begin
          wr_en = 1'b1;
          if (idx_q == IDX_W'(LAST_IDX)) begin
            idx_d = '0;
            if (feat_last) begin
              state_d  = S_EVAL;
              settle_d = SET_W'(SETTLE_CYCLES);
            end else begin
              err_d = 1'b1;
            end
          end else if (feat_last) begin
            idx_d = '0;
            err_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_EVAL: begin
        settle_d = settle_q - SET_W'(1);
        if (settle_q == SET_W'(1)) begin
          capture = 1'b1;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (res_ready) begin
          state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame index, settle counter, feature slots and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      settle_q  <= '0;
      res_valid <= 1'b0;
      res_data  <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < N_FEAT; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      idx_q     <= idx_d;
      settle_q  <= settle_d;
      frame_err <= err_d;
      for (int i = 0; i < N_FEAT; i++) begin
        if (wr_en && (idx_q == IDX_W'(i))) begin
          slot_q[i] <= feat_data;
        end
      end
      if (capture) begin
        res_valid <= 1'b1;
        res_data  <= cls_out;
      end else if ((state_q == S_OUT) && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

  // Saturating statistics counters; clear takes priority over a capture.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      sample_cnt <= '0;
      pos_cnt    <= '0;
    end else if (capture) begin
      if (sample_cnt != CNT_MAX) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
      end
      if (cls_out && (pos_cnt != CNT_MAX)) begin
        pos_cnt <= pos_cnt + CNT_W'(1);
      end
    end
  end

  assign cls_a = slot_q[0];
  assign cls_b = slot_q[1];
  assign cls_c = slot_q[2];
  assign cls_d = slot_q[3];
  assign cls_e = slot_q[4];
  assign cls_f = slot_q[5];
  assign cls_g = slot_q[6];

endmodule
